// File: rtl/band_envelope_scheduler_pkg.sv
// rtl/band_envelope_scheduler_pkg.sv - shared Q14 constants, band indices, FSM encoding and LFSR step
package band_envelope_scheduler_pkg;

  localparam int ENV_UNITY = 16384;
  localparam int ENV_MIN   = 8192;
  localparam int ENV_MAX   = 24576;

  localparam int BAND_THETA = 0;
  localparam int BAND_ALPHA = 1;
  localparam int BAND_BETA  = 2;
  localparam int BAND_GAMMA = 3;
  localparam int NUM_BANDS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_DRAW_T = 3'd2,
    ST_DRAW_H = 3'd3,
    ST_SMOOTH = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Galois step; the taps fold back in when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/band_envelope_scheduler_lfsr.sv
// rtl/band_envelope_scheduler_lfsr.sv - 16-bit Galois LFSR that advances only when stepped
module lfsr16_galois
  import band_envelope_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (step) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/band_envelope_scheduler.sv
// rtl/band_envelope_scheduler.sv - round-robin scheduler drifting four band envelopes toward random targets
module band_envelope_scheduler
  import band_envelope_scheduler_pkg::*;
#(
  parameter int          WIDTH         = 18,
  parameter int          FRAC          = 14,
  parameter int          SMOOTH_SHIFT  = 10,
  parameter int          HOLD_MIN      = 8000,
  parameter int          HOLD_JIT_BITS = 12,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             enable,
  output logic [WIDTH-1:0] env_theta,
  output logic [WIDTH-1:0] env_alpha,
  output logic [WIDTH-1:0] env_beta,
  output logic [WIDTH-1:0] env_gamma,
  output logic             env_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int HOLD_W = $clog2(HOLD_MIN + (1 << HOLD_JIT_BITS));
  localparam int DW     = WIDTH + 1;
  localparam logic signed [WIDTH-1:0] UNITY_W = WIDTH'(1 << FRAC);

  state_e                   state_q, state_d;
  logic [1:0]               band_q, band_d;
  logic signed [WIDTH-1:0]  env_q [NUM_BANDS];
  logic signed [WIDTH-1:0]  env_d [NUM_BANDS];
  logic signed [WIDTH-1:0]  tgt_q [NUM_BANDS];
  logic signed [WIDTH-1:0]  tgt_d [NUM_BANDS];
  logic signed [WIDTH-1:0]  out_q [NUM_BANDS];
  logic signed [WIDTH-1:0]  out_d [NUM_BANDS];
  logic [HOLD_W-1:0]        hold_q [NUM_BANDS];
  logic [HOLD_W-1:0]        hold_d [NUM_BANDS];
  logic                     env_valid_q, env_valid_d;
  logic                     overrun_q, overrun_d;

  logic                     lfsr_step;
  logic [15:0]              lfsr_s;
  logic [13:0]              draw;
  logic [WIDTH-1:0]         tgt_raw;
  logic signed [DW-1:0]     env_x, diff, sum;
  logic signed [WIDTH-1:0]  env_new;

  lfsr16_galois #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .state (lfsr_s)
  );

  // Draws use the post-step value, so look one step ahead of the register.
  assign draw    = 14'(lfsr_next(lfsr_s));
  assign tgt_raw = WIDTH'(ENV_MIN) + WIDTH'(draw);

  // Single shared smoothing datapath, steered by the current band index.
  always_comb begin
    env_x = $signed({env_q[band_q][WIDTH-1], env_q[band_q]});
    diff  = $signed({tgt_q[band_q][WIDTH-1], tgt_q[band_q]}) - env_x;
    sum   = env_x + (diff >>> SMOOTH_SHIFT);
    if (sum < DW'(ENV_MIN))      env_new = WIDTH'(ENV_MIN);
    else if (sum > DW'(ENV_MAX)) env_new = WIDTH'(ENV_MAX);
    else                         env_new = $signed(sum[WIDTH-1:0]);
  end

  always_comb begin
    state_d     = state_q;
    band_d      = band_q;
    env_d       = env_q;
    tgt_d       = tgt_q;
    out_d       = out_q;
    hold_d      = hold_q;
    env_valid_d = 1'b0;
    overrun_d   = overrun_q | (clk_en & (state_q != ST_IDLE));
    lfsr_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clk_en && enable) begin
          band_d  = 2'd0;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (hold_q[band_q] == '0) begin
          state_d = ST_DRAW_T;
        end else begin
          hold_d[band_q] = hold_q[band_q] - HOLD_W'(1);
          state_d        = ST_SMOOTH;
        end
      end
      ST_DRAW_T: begin
        lfsr_step     = 1'b1;
        tgt_d[band_q] = $signed(tgt_raw);
        state_d       = ST_DRAW_H;
      end
      ST_DRAW_H: begin
        lfsr_step      = 1'b1;
        hold_d[band_q] = HOLD_W'(HOLD_MIN) + HOLD_W'(draw[HOLD_JIT_BITS-1:0]);
        state_d        = ST_SMOOTH;
      end
      ST_SMOOTH: begin
        env_d[band_q] = env_new;
        if (band_q == 2'd3) begin
          state_d = ST_COMMIT;
        end else begin
          band_d  = band_q + 2'd1;
          state_d = ST_EVAL;
        end
      end
      ST_COMMIT: begin
        out_d       = env_q;
        env_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      band_q      <= 2'd0;
      env_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        env_q[b]  <= UNITY_W;
        tgt_q[b]  <= UNITY_W;
        out_q[b]  <= UNITY_W;
        hold_q[b] <= '0;
      end
    end else begin
      state_q     <= state_d;
      band_q      <= band_d;
      env_valid_q <= env_valid_d;
      overrun_q   <= overrun_d;
      env_q       <= env_d;
      tgt_q       <= tgt_d;
      out_q       <= out_d;
      hold_q      <= hold_d;
    end
  end

  assign env_theta = out_q[BAND_THETA];
  assign env_alpha = out_q[BAND_ALPHA];
  assign env_beta  = out_q[BAND_BETA];
  assign env_gamma = out_q[BAND_GAMMA];
  assign env_valid = env_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule
